// File: rtl/pll_reset_sequencer.sv
// Staged reset release behind the 48 MHz PLL: system reset drops once lock has been
// stable long enough, USB reset and ready follow a fixed gap later. Lock losses are counted.
module pll_reset_sequencer #(
  parameter int LOCK_STABLE_CYCLES = 4800,
  parameter int STAGE_GAP_CYCLES   = 48,
  parameter int LOSS_CNT_W         = 8
) (
  input  logic                  clk_48mhz,
  input  logic                  rst,
  input  logic                  nlocked,
  output logic                  sys_rst,
  output logic                  usb_rst,
  output logic                  ready,
  output logic [1:0]            state,
  output logic [LOSS_CNT_W-1:0] loss_count
);

  localparam int MAX_CYC = (LOCK_STABLE_CYCLES > STAGE_GAP_CYCLES) ?
                           LOCK_STABLE_CYCLES : STAGE_GAP_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC) + 1;
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST    = CNT_W'(STAGE_GAP_CYCLES - 1);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    STABLE    = 2'd1,
    SYS_UP    = 2'd2,
    RUN       = 2'd3
  } state_t;

  logic                  r_s1;
  logic                  r_s2;
  state_t                r_state;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_sys_rst;
  logic                  r_usb_rst;
  logic                  r_ready;
  logic [LOSS_CNT_W-1:0] r_loss;
  logic                  w_lock_s;

  assign w_lock_s = ~r_s2;

  // Outputs change only on the transitions that alter them, so they stay in step with r_state.
  always_ff @(posedge clk_48mhz) begin
    if (rst) begin
      r_s1      <= 1'b1;
      r_s2      <= 1'b1;
      r_state   <= WAIT_LOCK;
      r_cnt     <= '0;
      r_sys_rst <= 1'b1;
      r_usb_rst <= 1'b1;
      r_ready   <= 1'b0;
      r_loss    <= '0;
    end else begin
      r_s1 <= nlocked;
      r_s2 <= r_s1;
      unique case (r_state)
        WAIT_LOCK: begin
          if (w_lock_s) begin
            r_state <= STABLE;
            r_cnt   <= '0;
          end
        end
        STABLE: begin
          if (!w_lock_s) begin
            r_state <= WAIT_LOCK;
            r_cnt   <= '0;
          end else if (r_cnt == STABLE_LAST) begin
            r_state   <= SYS_UP;
            r_cnt     <= '0;
            r_sys_rst <= 1'b0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        SYS_UP: begin
          if (!w_lock_s) begin
            r_state   <= WAIT_LOCK;
            r_cnt     <= '0;
            r_sys_rst <= 1'b1;
            if (r_loss != '1) r_loss <= r_loss + LOSS_CNT_W'(1);
          end else if (r_cnt == GAP_LAST) begin
            r_state   <= RUN;
            r_cnt     <= '0;
            r_usb_rst <= 1'b0;
            r_ready   <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        RUN: begin
          if (!w_lock_s) begin
            r_state   <= WAIT_LOCK;
            r_cnt     <= '0;
            r_sys_rst <= 1'b1;
            r_usb_rst <= 1'b1;
            r_ready   <= 1'b0;
            if (r_loss != '1) r_loss <= r_loss + LOSS_CNT_W'(1);
          end
        end
        default: begin
          r_state <= WAIT_LOCK;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign sys_rst    = r_sys_rst;
  assign usb_rst    = r_usb_rst;
  assign ready      = r_ready;
  assign state      = r_state;
  assign loss_count = r_loss;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Randomized bench for pll_reset_sequencer; expected outputs come from the length of the
// current uninterrupted run of synchronized lock, which fully determines the sequencer phase.
module tb_pll_reset_sequencer;

  localparam int LSC = 8;
  localparam int GAP = 4;
  localparam int LW  = 2;
  localparam int LOSS_MAX = (1 << LW) - 1;

  logic          clk_48mhz = 1'b0;
  logic          rst       = 1'b1;
  logic          nlocked   = 1'b1;
  logic          sys_rst;
  logic          usb_rst;
  logic          ready;
  logic [1:0]    state;
  logic [LW-1:0] loss_count;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: lock run length and loss tally.
  logic m_s1 = 1'b1;
  logic m_s2 = 1'b1;
  int   m_run  = 0;
  int   m_loss = 0;

  pll_reset_sequencer #(
    .LOCK_STABLE_CYCLES(LSC),
    .STAGE_GAP_CYCLES  (GAP),
    .LOSS_CNT_W        (LW)
  ) dut (
    .clk_48mhz (clk_48mhz),
    .rst       (rst),
    .nlocked   (nlocked),
    .sys_rst   (sys_rst),
    .usb_rst   (usb_rst),
    .ready     (ready),
    .state     (state),
    .loss_count(loss_count)
  );

  always #5 clk_48mhz = ~clk_48mhz;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0d, expected %0d", tag, $time, obs, exp);
    end
  endtask

  function automatic int exp_state(input int run);
    if (run == 0)              return 0;
    else if (run <= LSC)       return 1;
    else if (run <= LSC + GAP) return 2;
    else                       return 3;
  endfunction

  // Advance the model by one edge using the inputs present at that edge.
  task automatic model_edge();
    logic lk;
    if (rst) begin
      m_s1 = 1'b1; m_s2 = 1'b1; m_run = 0; m_loss = 0;
    end else begin
      lk   = ~m_s2;
      m_s2 = m_s1;
      m_s1 = nlocked;
      if (lk) begin
        if (m_run <= LSC + GAP) m_run++;
      end else begin
        if (m_run > LSC && m_loss < LOSS_MAX) m_loss++;
        m_run = 0;
      end
    end
  endtask

  task automatic step(input logic r, input logic nl, input int ncyc);
    int es;
    for (int i = 0; i < ncyc; i++) begin
      rst     = r;
      nlocked = nl;
      @(posedge clk_48mhz);
      model_edge();
      #1;
      es = exp_state(m_run);
      check("state",      32'(state),      32'(es));
      check("sys_rst",    32'(sys_rst),    32'(es < 2));
      check("usb_rst",    32'(usb_rst),    32'(es != 3));
      check("ready",      32'(ready),      32'(es == 3));
      check("loss_count", 32'(loss_count), 32'(m_loss));
    end
  endtask

  initial begin
    // Power-up and full sequence.
    step(1'b1, 1'b1, 3);
    step(1'b0, 1'b0, 20);
    // Glitch during the stable count, then relock.
    step(1'b0, 1'b1, 1);
    step(1'b0, 1'b0, 7);
    step(1'b0, 1'b1, 2);
    step(1'b0, 1'b0, 20);
    // Loss just after system reset release.
    step(1'b0, 1'b1, 2);
    step(1'b0, 1'b0, 12);
    step(1'b0, 1'b1, 2);
    // Repeated losses from RUN to reach saturation.
    for (int k = 0; k < 5; k++) begin
      step(1'b0, 1'b0, 18);
      step(1'b0, 1'b1, 2);
    end
    // Reset pulse while in SYS_UP.
    step(1'b0, 1'b0, 12);
    step(1'b1, 1'b0, 1);
    step(1'b0, 1'b0, 20);
    // Random segments.
    for (int k = 0; k < 250; k++) begin
      if ($urandom_range(0, 99) < 6) begin
        step(1'b1, 1'($urandom_range(0, 1)), $urandom_range(1, 2));
      end else begin
        step(1'b0, 1'b0, $urandom_range(1, 22));
        step(1'b0, 1'b1, $urandom_range(1, 3));
      end
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
